sm3_msg_arb: RTL and testbench
==============================

# sm3_msg_arb

Round-robin arbiter that shares one SM3 padding/compression pipeline between `N_REQ` message sources. A requester is granted for a whole message: the grant locks from the first beat until the last beat is accepted, and is then held until the pipeline reports the digest. The block sits between the requester ports and the pad core's message-input interface. It tags each digest with the owning requester's index so results can be routed back.

## Interface
- `N_REQ`, default 2: number of requesters, legal range 2..4.
- `DW`, default 64: message data width; must match the pad core input width.
- `VB_W`, default `DW/8`: width of the valid-byte field.
- `ID_W`, default `$clog2(N_REQ)`: requester index width.

Ports:
- `clk`  in  1  Single clock.
- `rst`  in  1  Reset, asynchronous, active-high.
- `req_vld_i`  in  N_REQ  Per-requester beat valid.
- `req_d_i`  in  N_REQ*DW  Per-requester data; requester k occupies bits [k*DW +: DW].
- `req_vld_byte_i`  in  N_REQ*VB_W  Per-requester valid-byte field.
- `req_lst_i`  in  N_REQ  Per-requester last-beat flag.
- `req_rdy_o`  out  N_REQ  Per-requester ready.
- `msg_inpt_d_o`  out  DW  To pad core.
- `msg_inpt_vld_byte_o`  out  VB_W  To pad core.
- `msg_inpt_vld_o`  out  1  To pad core.
- `msg_inpt_lst_o`  out  1  To pad core.
- `msg_inpt_rdy_i`  in  1  From pad core.
- `dgst_vld_i`  in  1  One-cycle pulse: the digest for the current message is complete.
- `gnt_o`  out  N_REQ  One-hot current grant, registered.
- `gnt_id_o`  out  ID_W  Index of the current grant, registered.
- `busy_o`  out  1  High whenever the state is not IDLE.
- `dgst_vld_o`  out  1  Digest-valid pulse, tagged with the owner.
- `dgst_id_o`  out  ID_W  Owner index of the digest.
- `spur_o`  out  1  One-cycle pulse on an unexpected `dgst_vld_i`.

## Operation
- FSM states: IDLE, XFER, WAIT.
- IDLE:
  - If any `req_vld_i` bit is set, select the winner round-robin, searching upward from `last_ptr+1` modulo `N_REQ`.
  - Register `gnt_o` and `gnt_id_o` with the winner and go to XFER.
  - Otherwise stay in IDLE.
- XFER: the granted requester g is connected combinationally.
  - `msg_inpt_*_o` carry requester g's data, valid-byte field, valid and last.
  - `req_rdy_o[g]` = `msg_inpt_rdy_i`.
  - All other `req_rdy_o` bits are 0.
  - When `msg_inpt_vld_o & msg_inpt_rdy_i & msg_inpt_lst_o`, go to WAIT.
- WAIT: all `req_rdy_o` bits are 0 and `msg_inpt_vld_o` is 0.
  - On `dgst_vld_i`: `dgst_vld_o`=1 and `dgst_id_o`=`gnt_id_o` in the same cycle, combinationally.
  - In that same cycle, `last_ptr` is loaded with `gnt_id_o`, `gnt_o` is cleared, and the FSM returns to IDLE.
- Outside XFER, all `msg_inpt_*_o` outputs are driven to 0.
- `dgst_vld_i` in IDLE or XFER is ignored for routing: it produces `spur_o`=1 for one cycle, `dgst_vld_o` stays 0 and the state does not change.
- The grant never changes mid-message. Requesters that deassert valid in XFER simply stall the transfer; there is no timeout.
- A single-beat message (first beat carries `lst`) goes XFER→WAIT on that beat.

## Timing
- Reset values:
  - FSM = IDLE.
  - `last_ptr` = `N_REQ-1`, so requester 0 has first priority.
  - `gnt_o`=0, `gnt_id_o`=0, `busy_o`=0.
  - `req_rdy_o`=0, all `msg_inpt_*_o`=0.
  - `dgst_vld_o`=0, `dgst_id_o`=0, `spur_o`=0.
- Reset asserted mid-message clears everything immediately and asynchronously. The partial message is abandoned; the pad core is reset by the same `rst`.
- Arbitration latency: a request visible in IDLE at cycle 0 gives `gnt_o` at cycle 1. The first beat can transfer at cycle 1 (`req_rdy_o[g]` follows `msg_inpt_rdy_i`).
- Throughput in XFER: one beat per cycle when the pad core is ready. The data path has zero added latency; it is purely a mux.
- Re-arbitration gap: the cycle after `dgst_vld_i` is IDLE, and the next grant is visible one cycle later. This gives 2 cycles from the digest to the next grant.
- Round-robin wrap: with `last_ptr`=`N_REQ-1`, the search order is 0,1,…,`N_REQ-1`.

## Test plan
- **Single requester, 3-beat message.** Drive req0 with beats D0..D2, `lst` on D2; pad core ready throughout; pulse `dgst_vld_i` 5 cycles later. Expect `gnt_o`=01 at cycle 1; D0..D2 appear on `msg_inpt_d_o` at cycles 1..3; `busy_o`=1 until the digest; `dgst_vld_o`=1 with `dgst_id_o`=0; return to IDLE.
- **Fairness.** With `N_REQ`=3 and all requesters holding 1-beat messages continuously, the grant order after reset is 0,1,2,0,1,2, with exactly one digest per grant.
- **Backpressure and stall.** Toggle `msg_inpt_rdy_i` 1-0-1 and drop the granted `req_vld_i` for 2 cycles mid-message. Expect the grant to hold, no beat dropped or duplicated, and non-granted `req_rdy_o`=0 throughout.
- **Spurious digest.** Pulse `dgst_vld_i` in IDLE and again in XFER. Expect `spur_o`=1 for one cycle each time, `dgst_vld_o`=0, and no state change.
- **Reset mid-message.** Assert `rst` during beat 2 of req1's message. Expect all outputs 0 immediately; after release, `last_ptr`=`N_REQ-1`, so simultaneous req0 and req1 requests grant req0 first.
- **Lock on last beat.** Send a 1-beat message from req1 while req0 is also requesting. Expect the FSM to go XFER→WAIT on that beat; req0 is not granted until 2 cycles after `dgst_vld_i`.

Source files
------------

// File: rtl/sm3_msg_arb_if.sv
// Requester-side and pad-core-side signal bundle for sm3_msg_arb.
// The slave modport is the arbiter; master is the surrounding requesters and pad core.
interface sm3_msg_arb_if #(
  parameter int N_REQ = 2,
  parameter int DW    = 64,
  parameter int VB_W  = DW / 8,
  parameter int ID_W  = $clog2(N_REQ)
);
  logic [N_REQ-1:0]      req_vld_i;
  logic [N_REQ*DW-1:0]   req_d_i;
  logic [N_REQ*VB_W-1:0] req_vld_byte_i;
  logic [N_REQ-1:0]      req_lst_i;
  logic [N_REQ-1:0]      req_rdy_o;
  logic [DW-1:0]         msg_inpt_d_o;
  logic [VB_W-1:0]       msg_inpt_vld_byte_o;
  logic                  msg_inpt_vld_o;
  logic                  msg_inpt_lst_o;
  logic                  msg_inpt_rdy_i;
  logic                  dgst_vld_i;
  logic [N_REQ-1:0]      gnt_o;
  logic [ID_W-1:0]       gnt_id_o;
  logic                  busy_o;
  logic                  dgst_vld_o;
  logic [ID_W-1:0]       dgst_id_o;
  logic                  spur_o;

  modport slave (
    input  req_vld_i, req_d_i, req_vld_byte_i, req_lst_i, msg_inpt_rdy_i, dgst_vld_i,
    output req_rdy_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_vld_o, msg_inpt_lst_o,
           gnt_o, gnt_id_o, busy_o, dgst_vld_o, dgst_id_o, spur_o
  );

  modport master (
    output req_vld_i, req_d_i, req_vld_byte_i, req_lst_i, msg_inpt_rdy_i, dgst_vld_i,
    input  req_rdy_o, msg_inpt_d_o, msg_inpt_vld_byte_o, msg_inpt_vld_o, msg_inpt_lst_o,
           gnt_o, gnt_id_o, busy_o, dgst_vld_o, dgst_id_o, spur_o
  );
endinterface

// File: rtl/sm3_msg_arb.sv
// Round-robin, message-locked arbiter sharing one SM3 pad/compression pipeline
// between N_REQ sources; digests are tagged with the owning requester index.
module sm3_msg_arb #(
  parameter int N_REQ = 2,
  parameter int DW    = 64,
  parameter int VB_W  = DW / 8,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input logic         clk,
  input logic         rst,
  sm3_msg_arb_if.slave bus
);
  localparam int unsigned NR = N_REQ;

  typedef enum logic [1:0] {IDLE, XFER, WAIT} state_t;

  state_t           state;
  logic [ID_W-1:0]  last_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic [N_REQ-1:0] gnt;
  logic [ID_W-1:0]  win_id;
  logic             win_vld;
  int unsigned      cand;

  // Upward search starting just above the previous owner, wrapping modulo N_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    cand    = 0;
    for (int unsigned i = 1; i <= NR; i++) begin
      cand = (int'(last_ptr) + i) % NR;
      if (!win_vld && bus.req_vld_i[ID_W'(cand)]) begin
        win_vld = 1'b1;
        win_id  = ID_W'(cand);
      end
    end
  end

  always_comb begin
    bus.req_rdy_o           = '0;
    bus.msg_inpt_d_o        = '0;
    bus.msg_inpt_vld_byte_o = '0;
    bus.msg_inpt_vld_o      = 1'b0;
    bus.msg_inpt_lst_o      = 1'b0;
    if (state == XFER) begin
      for (int unsigned k = 0; k < NR; k++) begin
        if (gnt_id == ID_W'(k)) begin
          bus.msg_inpt_d_o        = bus.req_d_i[k*DW +: DW];
          bus.msg_inpt_vld_byte_o = bus.req_vld_byte_i[k*VB_W +: VB_W];
          bus.msg_inpt_vld_o      = bus.req_vld_i[k];
          bus.msg_inpt_lst_o      = bus.req_lst_i[k];
          bus.req_rdy_o[k]        = bus.msg_inpt_rdy_i;
        end
      end
    end
  end

  // Only a digest arriving while a message is outstanding is routed; any other is flagged.
  assign bus.dgst_vld_o = (state == WAIT) && bus.dgst_vld_i;
  assign bus.dgst_id_o  = bus.dgst_vld_o ? gnt_id : '0;
  assign bus.spur_o     = (state != WAIT) && bus.dgst_vld_i;
  assign bus.gnt_o      = gnt;
  assign bus.gnt_id_o   = gnt_id;
  assign bus.busy_o     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_ptr <= ID_W'(N_REQ - 1);
      gnt      <= '0;
      gnt_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_vld) begin
            gnt    <= N_REQ'(1) << win_id;
            gnt_id <= win_id;
            state  <= XFER;
          end
        end
        XFER: begin
          if (bus.msg_inpt_vld_o && bus.msg_inpt_rdy_i && bus.msg_inpt_lst_o)
            state <= WAIT;
        end
        WAIT: begin
          if (bus.dgst_vld_i) begin
            last_ptr <= gnt_id;
            gnt      <= '0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sm3_msg_arb.sv
// Self-checking bench for sm3_msg_arb: per-requester beat queues feed the DUT and a
// message-level model (owner, round-robin pointer, done flag) predicts every output.
module tb_sm3_msg_arb;
  localparam int N   = 3;
  localparam int DW  = 64;
  localparam int VBW = 8;
  localparam int IDW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm3_msg_arb_if #(.N_REQ(N), .DW(DW), .VB_W(VBW), .ID_W(IDW)) bus ();
  sm3_msg_arb #(.N_REQ(N), .DW(DW), .VB_W(VBW), .ID_W(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [DW-1:0]  d;
    logic [VBW-1:0] vb;
    logic           lst;
  } beat_t;

  beat_t src_q [N][$];
  bit    stall [N];
  bit    pad_rdy;
  bit    force_dg;
  bit    cur_dg;
  int    auto_dg;
  int    m_ptr, m_owner, wait_cnt, n_dgst;
  bit    m_done;
  int    gnt_log[$];
  int    n_chk = 0;
  int    n_pass = 0;
  int    n_fail = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input int k, input int nbeats);
    beat_t b;
    for (int i = 0; i < nbeats; i++) begin
      b.d   = {$urandom, $urandom};
      b.vb  = VBW'($urandom);
      b.lst = (i == nbeats - 1);
      src_q[k].push_back(b);
    end
  endtask

  task automatic drive();
    beat_t b;
    for (int k = 0; k < N; k++) begin
      b = '0;
      if (src_q[k].size() > 0) b = src_q[k][0];
      bus.req_vld_i[k]               = (src_q[k].size() > 0) && !stall[k];
      bus.req_d_i[k*DW +: DW]        = b.d;
      bus.req_vld_byte_i[k*VBW +: VBW] = b.vb;
      bus.req_lst_i[k]               = b.lst;
    end
    bus.msg_inpt_rdy_i = pad_rdy;
    cur_dg = force_dg || (m_owner >= 0 && m_done && auto_dg > 0 && wait_cnt == auto_dg);
    bus.dgst_vld_i = cur_dg;
  endtask

  // One clock: present inputs, check outputs against the model, advance the model.
  task automatic cycle();
    logic [N-1:0] vld, exp_gnt, exp_rdy;
    beat_t        cur;
    bit           active, found, fin;
    int           k;
    drive();
    vld     = bus.req_vld_i;
    #2;
    active  = (m_owner >= 0) && !m_done;
    fin     = (m_owner >= 0) && m_done;
    exp_gnt = '0;
    exp_rdy = '0;
    cur     = '0;
    if (m_owner >= 0) begin
      exp_gnt[m_owner] = 1'b1;
      if (src_q[m_owner].size() > 0) cur = src_q[m_owner][0];
    end
    if (active && pad_rdy) exp_rdy[m_owner] = 1'b1;
    check("gnt", bus.gnt_o, exp_gnt);
    if (m_owner >= 0) check("gnt_id", bus.gnt_id_o, m_owner);
    check("busy", bus.busy_o, m_owner >= 0);
    check("req_rdy", bus.req_rdy_o, exp_rdy);
    check("msg_vld", bus.msg_inpt_vld_o, active && vld[m_owner]);
    check("msg_d", bus.msg_inpt_d_o, active ? cur.d : '0);
    check("msg_vb", bus.msg_inpt_vld_byte_o, active ? cur.vb : '0);
    check("msg_lst", bus.msg_inpt_lst_o, active ? cur.lst : 1'b0);
    check("dgst_vld", bus.dgst_vld_o, cur_dg && fin);
    check("dgst_id", bus.dgst_id_o, (cur_dg && fin) ? m_owner : 0);
    check("spur", bus.spur_o, cur_dg && !fin);
    if (m_owner < 0) begin
      found = 1'b0;
      for (int i = 1; i <= N; i++) begin
        k = (m_ptr + i) % N;
        if (!found && vld[k]) begin
          found   = 1'b1;
          m_owner = k;
          gnt_log.push_back(k);
        end
      end
    end else if (!m_done) begin
      if (vld[m_owner] && pad_rdy) begin
        if (src_q[m_owner][0].lst) begin
          m_done   = 1'b1;
          wait_cnt = 0;
        end
        void'(src_q[m_owner].pop_front());
      end
    end else if (cur_dg) begin
      n_dgst++;
      m_ptr   = m_owner;
      m_owner = -1;
      m_done  = 1'b0;
    end else begin
      wait_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // Asserts reset mid-cycle with the current inputs still applied; outputs must clear at once.
  task automatic do_reset();
    drive();
    bus.dgst_vld_i = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_gnt", bus.gnt_o, 0);
    check("rst_gnt_id", bus.gnt_id_o, 0);
    check("rst_busy", bus.busy_o, 0);
    check("rst_rdy", bus.req_rdy_o, 0);
    check("rst_msg", {bus.msg_inpt_d_o, bus.msg_inpt_vld_byte_o, bus.msg_inpt_vld_o, bus.msg_inpt_lst_o}, 0);
    check("rst_dgst", {bus.dgst_vld_o, bus.dgst_id_o, bus.spur_o}, 0);
    for (int k = 0; k < N; k++) begin
      src_q[k].delete();
      stall[k] = 1'b0;
    end
    force_dg = 1'b0;
    pad_rdy  = 1'b1;
    auto_dg  = 0;
    drive();
    m_ptr    = N - 1;
    m_owner  = -1;
    m_done   = 1'b0;
    wait_cnt = 0;
    n_dgst   = 0;
    gnt_log.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    m_owner = -1;
    #1;
    do_reset();

    // Single requester, three beats, digest five cycles after the last beat.
    auto_dg = 5;
    load(0, 3);
    run(12);
    check("t1_log_n", gnt_log.size(), 1);
    check("t1_owner", gnt_log[0], 0);
    check("t1_dgst_n", n_dgst, 1);
    check("t1_drained", src_q[0].size(), 0);

    // One-beat message from req1 locks out req0 until after its digest.
    auto_dg = 3;
    load(1, 1);
    load(0, 2);
    run(20);
    check("t2_log_n", gnt_log.size(), 3);
    check("t2_first", gnt_log[1], 1);
    check("t2_second", gnt_log[2], 0);
    check("t2_dgst_n", n_dgst, 3);

    // Spurious digest in IDLE, then again during XFER.
    auto_dg  = 0;
    force_dg = 1'b1;
    cycle();
    force_dg = 1'b0;
    cycle();
    load(2, 4);
    cycle();
    force_dg = 1'b1;
    cycle();
    force_dg = 1'b0;
    auto_dg  = 2;
    run(12);
    check("t3_owner", gnt_log[3], 2);
    check("t3_dgst_n", n_dgst, 4);
    check("t3_drained", src_q[2].size(), 0);

    // Backpressure and requester stalls, then a clean drain.
    load(1, 5);
    load(0, 2);
    load(2, 1);
    for (int c = 0; c < 40; c++) begin
      pad_rdy = ($urandom_range(0, 2) != 0);
      for (int k = 0; k < N; k++) stall[k] = ($urandom_range(0, 3) == 0);
      cycle();
    end
    pad_rdy = 1'b1;
    for (int k = 0; k < N; k++) stall[k] = 1'b0;
    run(40);
    check("t4_drained", src_q[0].size() + src_q[1].size() + src_q[2].size(), 0);
    check("t4_dgst_n", n_dgst, 7);

    // Reset in the middle of req1's message, then req0 and req1 together.
    do_reset();
    load(1, 4);
    run(3);
    check("t5_busy_pre", bus.busy_o, 1);
    do_reset();
    auto_dg = 1;
    load(0, 1);
    load(1, 1);
    run(12);
    check("t5_log_n", gnt_log.size(), 2);
    check("t5_first", gnt_log[0], 0);
    check("t5_second", gnt_log[1], 1);

    // Fairness: all requesters hold one-beat messages continuously.
    do_reset();
    auto_dg = 1;
    for (int k = 0; k < N; k++) begin
      load(k, 1);
      load(k, 1);
    end
    run(40);
    check("t6_log_n", gnt_log.size(), 6);
    for (int i = 0; i < 6 && i < gnt_log.size(); i++) check("t6_order", gnt_log[i], i % N);
    check("t6_dgst_n", n_dgst, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
